// File: rtl/hedios_pkg.sv
// rtl/hedios_pkg.sv - Hedios endpoint command codes, packet widths and tx arbiter FSM encoding
package hedios_pkg;

  localparam int HEDIOS_CMD_W  = 8;
  localparam int HEDIOS_DATA_W = 32;

  typedef logic [HEDIOS_CMD_W-1:0]  hedios_cmd_t;
  typedef logic [HEDIOS_DATA_W-1:0] hedios_data_t;

  localparam hedios_cmd_t HDC_NOP       = 8'h00;
  localparam hedios_cmd_t HDC_REG_WRITE = 8'h01;
  localparam hedios_cmd_t HDC_REG_READ  = 8'h02;
  localparam hedios_cmd_t HDC_STATUS    = 8'h03;
  localparam hedios_cmd_t HDC_DATA      = 8'h04;
  localparam hedios_cmd_t HDC_IRQ       = 8'h05;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/hedios_rr_picker.sv
// rtl/hedios_rr_picker.sv - round-robin pick over ports 1..REQ_COUNT-1 starting at rr_ptr
module hedios_rr_picker #(
  parameter int REQ_COUNT = 4,
  parameter int PTR_W     = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req_mask,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic                 valid,
  output logic [PTR_W-1:0]     index
);

  logic [PTR_W-1:0] w_cand;

  // Port 0 never takes part; candidates walk rr_ptr, rr_ptr+1, ... wrapping inside 1..REQ_COUNT-1.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    w_cand = '0;
    for (int off = 0; off < REQ_COUNT - 1; off++) begin
      w_cand = PTR_W'((int'(rr_ptr) + REQ_COUNT - 2 + off) % (REQ_COUNT - 1) + 1);
      if (!valid && req_mask[w_cand]) begin
        valid = 1'b1;
        index = w_cand;
      end
    end
  end

endmodule

// File: rtl/hedios_tx_arbiter.sv
// rtl/hedios_tx_arbiter.sv - arbitrates requester packets into the Hedios serial tx queue
module hedios_tx_arbiter
  import hedios_pkg::*;
#(
  parameter int REQ_COUNT = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [REQ_COUNT-1:0]                     req,
  input  logic [REQ_COUNT-1:0]                     req_lock,
  input  logic [REQ_COUNT-1:0][HEDIOS_CMD_W-1:0]   req_command,
  input  logic [REQ_COUNT-1:0][HEDIOS_DATA_W-1:0]  req_data,
  output logic [REQ_COUNT-1:0]                     ack,
  input  logic                                     tx_full,
  output logic [HEDIOS_CMD_W-1:0]                  tx_command,
  output logic [HEDIOS_DATA_W-1:0]                 tx_data,
  output logic                                     tx_push_packet,
  output logic                                     busy
);

  localparam int PTR_W = $clog2(REQ_COUNT);

  logic [1:0]               r_state;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [PTR_W-1:0]         r_winner;
  logic                     r_lock_valid;
  logic [PTR_W-1:0]         r_lock_idx;
  logic [REQ_COUNT-1:0]     r_ack;
  logic                     r_push;
  logic [HEDIOS_CMD_W-1:0]  r_cmd;
  logic [HEDIOS_DATA_W-1:0] r_data;
  logic                     r_busy;

  logic                     w_rr_valid;
  logic [PTR_W-1:0]         w_rr_index;
  logic                     w_lock_active;
  logic                     w_grant;
  logic [PTR_W-1:0]         w_grant_idx;
  logic [REQ_COUNT-1:0]     w_grant_onehot;
  logic [PTR_W-1:0]         w_rr_next;
  logic [1:0]               w_state_nxt;
  logic                     w_lock_valid_nxt;
  logic [PTR_W-1:0]         w_lock_idx_nxt;
  logic                     w_busy_nxt;

  hedios_rr_picker #(
    .REQ_COUNT (REQ_COUNT),
    .PTR_W     (PTR_W)
  ) u_rr_picker (
    .req_mask (req),
    .rr_ptr   (r_rr_ptr),
    .valid    (w_rr_valid),
    .index    (w_rr_index)
  );

  // A lock only counts while its owner still asks for both the packet and the burst.
  assign w_lock_active  = r_lock_valid && req[r_lock_idx] && req_lock[r_lock_idx];
  assign w_grant        = !tx_full && (w_lock_active || req[0] || w_rr_valid);
  assign w_grant_idx    = w_lock_active ? r_lock_idx : (req[0] ? '0 : w_rr_index);
  assign w_grant_onehot = REQ_COUNT'(1) << w_grant_idx;
  assign w_rr_next      = (r_winner == PTR_W'(REQ_COUNT - 1)) ? PTR_W'(1) : r_winner + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_lock_valid_nxt = r_lock_valid;
    w_lock_idx_nxt   = r_lock_idx;
    case (r_state)
      ST_IDLE: begin
        if (!w_lock_active) w_lock_valid_nxt = 1'b0;
        if (w_grant)        w_state_nxt      = ST_PUSH;
      end
      ST_PUSH: begin
        w_state_nxt      = ST_GAP;
        w_lock_valid_nxt = req_lock[r_winner];
        w_lock_idx_nxt   = r_winner;
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE) || w_lock_valid_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= PTR_W'(1);
      r_winner     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      r_ack        <= '0;
      r_push       <= 1'b0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_valid <= w_lock_valid_nxt;
      r_lock_idx   <= w_lock_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_push       <= 1'b0;
      r_ack        <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_winner <= w_grant_idx;
            r_push   <= 1'b1;
            r_ack    <= w_grant_onehot;
            r_cmd    <= req_command[w_grant_idx];
            r_data   <= req_data[w_grant_idx];
          end
        end
        ST_PUSH: begin
          if (r_winner != '0) r_rr_ptr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

  assign ack            = r_ack;
  assign tx_push_packet = r_push;
  assign tx_command     = r_cmd;
  assign tx_data        = r_data;
  assign busy           = r_busy;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// tb/tb_hedios_tx_arbiter.sv - directed self-checking bench for hedios_tx_arbiter
module tb_hedios_tx_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0]       req_lock = '0;
  logic [3:0][7:0]  req_command;
  logic [3:0][31:0] req_data;
  logic [3:0]       ack;
  logic             tx_full = 1'b0;
  logic [7:0]       tx_command;
  logic [31:0]      tx_data;
  logic             tx_push_packet;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  hedios_tx_arbiter #(.REQ_COUNT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_lock       (req_lock),
    .req_command    (req_command),
    .req_data       (req_data),
    .ack            (ack),
    .tx_full        (tx_full),
    .tx_command     (tx_command),
    .tx_data        (tx_data),
    .tx_push_packet (tx_push_packet),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic wait_push(output logic [3:0] a, output logic [7:0] c, output logic [31:0] d,
                           output int at, output bit ok);
    ok = 1'b0; a = '0; c = '0; d = '0; at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (tx_push_packet === 1'b1) begin
        a = ack; c = tx_command; d = tx_data; at = cyc; ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (tx_push_packet !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: push=%b ack=%b busy=%b expected 0 0000 0", tx_push_packet, ack, busy);
    end
    n_tests++;
    if (tx_command !== 8'h00 || tx_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: cmd=%h data=%h expected 00 00000000", tx_command, tx_data);
    end
    n_tests++;
    if (dut.r_rr_ptr !== 2'd1 || dut.r_lock_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: rr_ptr=%0d lock=%b expected 1 0", dut.r_rr_ptr, dut.r_lock_valid);
    end
    req = 4'b0010;
    tick();
    rst_n = 1'b1;
    #2;
    n_tests++;
    if (tx_push_packet !== 1'b0) begin
      n_fail++; $display("FAIL release_no_early: push=%b expected 0", tx_push_packet);
    end
    tick();
    n_tests++;
    if (tx_push_packet !== 1'b1 || ack !== 4'b0010) begin
      n_fail++; $display("FAIL release_first_edge: push=%b ack=%b expected 1 0010", tx_push_packet, ack);
    end
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_push_packet !== 1'b0 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: push=%b ack=%b expected 0 0000", tx_push_packet, ack);
    end
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_rr_alternate();
    logic [3:0] a; logic [7:0] c; logic [31:0] d; int t0, t1, t2; bit ok;
    req = 4'b0110;
    wait_push(a, c, d, t0, ok);
    n_tests++;
    if (!ok || a !== 4'b0010 || c !== 8'h04 || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rr_push1: seen=%0d ack=%b cmd=%h data=%h expected 0010 04 deadbeef", ok, a, c, d);
    end
    wait_push(a, c, d, t1, ok);
    n_tests++;
    if (!ok || a !== 4'b0100 || c !== 8'h22 || (t1 - t0) != 3) begin
      n_fail++; $display("FAIL rr_push2: seen=%0d ack=%b cmd=%h gap=%0d expected 0100 22 3", ok, a, c, t1 - t0);
    end
    wait_push(a, c, d, t2, ok);
    req = 4'b0000;
    n_tests++;
    if (!ok || a !== 4'b0010 || (t2 - t1) != 3) begin
      n_fail++; $display("FAIL rr_push3: seen=%0d ack=%b gap=%0d expected 0010 3", ok, a, t2 - t1);
    end
    settle();
  endtask

  task automatic test_priority();
    logic [3:0] a; logic [7:0] c; logic [31:0] d; int t; bit ok;
    req = 4'b1001;
    wait_push(a, c, d, t, ok);
    req[0] = 1'b0;
    n_tests++;
    if (!ok || a !== 4'b0001 || c !== 8'h03 || d !== 32'h0000C0DE) begin
      n_fail++; $display("FAIL prio_port0: seen=%0d ack=%b cmd=%h data=%h expected 0001 03 0000c0de", ok, a, c, d);
    end
    wait_push(a, c, d, t, ok);
    req = 4'b0000;
    n_tests++;
    if (!ok || a !== 4'b1000 || c !== 8'h33 || d !== 32'h33333333) begin
      n_fail++; $display("FAIL prio_port3: seen=%0d ack=%b cmd=%h data=%h expected 1000 33 33333333", ok, a, c, d);
    end
    settle();
    n_tests++;
    if (dut.r_rr_ptr !== 2'd1) begin
      n_fail++; $display("FAIL prio_rr_ptr: rr_ptr=%0d expected 1", dut.r_rr_ptr);
    end
  endtask

  task automatic test_lock_burst();
    logic [3:0] a; logic [7:0] c; logic [31:0] d; int t; bit ok; int n_p2;
    n_p2 = 0;
    req = 4'b0100;
    req_lock = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      wait_push(a, c, d, t, ok);
      if (ok && a === 4'b0100) n_p2++;
      if (k == 0) req[0] = 1'b1;
      if (k == 4) begin req[2] = 1'b0; req_lock[2] = 1'b0; end
      if (k == 0) begin
        tick();
        n_tests++;
        if (dut.r_lock_valid !== 1'b1 || dut.r_lock_idx !== 2'd2) begin
          n_fail++; $display("FAIL lock_set: lock=%b idx=%0d expected 1 2", dut.r_lock_valid, dut.r_lock_idx);
        end
      end
    end
    n_tests++;
    if (n_p2 != 5) begin
      n_fail++; $display("FAIL lock_burst_count: port2 pushes=%0d expected 5", n_p2);
    end
    wait_push(a, c, d, t, ok);
    req = 4'b0000;
    n_tests++;
    if (!ok || a !== 4'b0001 || c !== 8'h03) begin
      n_fail++; $display("FAIL lock_then_port0: seen=%0d ack=%b cmd=%h expected 0001 03", ok, a, c);
    end
    settle();
    n_tests++;
    if (busy !== 1'b0 || dut.r_lock_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_released: busy=%b lock=%b expected 0 0", busy, dut.r_lock_valid);
    end
  endtask

  task automatic test_tx_full_stall();
    int n_push;
    n_push = 0;
    tx_full = 1'b1;
    req = 4'b0010;
    repeat (10) begin
      tick();
      if (tx_push_packet !== 1'b0 || ack !== 4'b0000) n_push++;
    end
    n_tests++;
    if (n_push != 0) begin
      n_fail++; $display("FAIL full_stall: cycles with push/ack=%0d expected 0", n_push);
    end
    tx_full = 1'b0;
    tick();
    n_tests++;
    if (tx_push_packet !== 1'b1 || ack !== 4'b0010 || tx_command !== 8'h04 || tx_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL full_release_push: push=%b ack=%b cmd=%h data=%h expected 1 0010 04 deadbeef",
                         tx_push_packet, ack, tx_command, tx_data);
    end
    tx_full = 1'b1;
    req = 4'b0000;
    tick();
    n_tests++;
    if (tx_push_packet !== 1'b0 || tx_command !== 8'h04 || tx_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL tx_hold: push=%b cmd=%h data=%h expected 0 04 deadbeef", tx_push_packet, tx_command, tx_data);
    end
    tx_full = 1'b0;
    settle();
  endtask

  task automatic test_reset_in_push();
    logic [3:0] a; logic [7:0] c; logic [31:0] d; int t; bit ok; int n_push;
    req = 4'b1000;
    req_lock = 4'b1000;
    wait_push(a, c, d, t, ok);
    wait_push(a, c, d, t, ok);
    n_tests++;
    if (!ok || a !== 4'b1000) begin
      n_fail++; $display("FAIL rstpush_second: seen=%0d ack=%b expected 1000", ok, a);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_push_packet !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || tx_command !== 8'h00) begin
      n_fail++; $display("FAIL rstpush_kill: push=%b ack=%b busy=%b cmd=%h expected 0 0000 0 00",
                         tx_push_packet, ack, busy, tx_command);
    end
    req = 4'b0000;
    req_lock = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    n_push = 0;
    repeat (5) begin
      tick();
      if (tx_push_packet !== 1'b0 || ack !== 4'b0000) n_push++;
    end
    n_tests++;
    if (n_push != 0 || dut.r_rr_ptr !== 2'd1 || dut.r_lock_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstpush_after: push cycles=%0d rr_ptr=%0d lock=%b expected 0 1 0",
                         n_push, dut.r_rr_ptr, dut.r_lock_valid);
    end
  endtask

  task automatic test_gap_pulse();
    logic [3:0] a; logic [7:0] c; logic [31:0] d; int t; bit ok; int n_push;
    req = 4'b0100;
    wait_push(a, c, d, t, ok);
    req = 4'b0000;
    n_tests++;
    if (!ok || a !== 4'b0100) begin
      n_fail++; $display("FAIL gap_setup: seen=%0d ack=%b expected 0100", ok, a);
    end
    tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    n_push = 0;
    repeat (6) begin
      tick();
      if (tx_push_packet !== 1'b0 || ack !== 4'b0000) n_push++;
    end
    n_tests++;
    if (n_push != 0) begin
      n_fail++; $display("FAIL gap_pulse: push/ack cycles=%0d expected 0", n_push);
    end
  endtask

  initial begin
    req_command[0] = 8'h03; req_data[0] = 32'h0000C0DE;
    req_command[1] = 8'h04; req_data[1] = 32'hDEADBEEF;
    req_command[2] = 8'h22; req_data[2] = 32'h22222222;
    req_command[3] = 8'h33; req_data[3] = 32'h33333333;
    test_reset();
    test_rr_alternate();
    test_priority();
    test_lock_burst();
    test_tx_full_stall();
    test_reset_in_push();
    test_gap_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hedios_tx_arbiter.md
HEDIOS_TX_ARBITER -- requirements
Module: hedios_tx_arbiter

Interface
REQ-001 The block SHALL have parameter REQ_COUNT, default 4, giving the number of requester ports (2..16); port 0 is the controller port.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, REQ_COUNT bits: per-port request level.
REQ-005 The block SHALL have port req_lock, input, REQ_COUNT bits: per-port request to keep the grant for consecutive packets (burst).
REQ-006 The block SHALL have port req_command, input, REQ_COUNT x 8 bits: per-port packet command.
REQ-007 The block SHALL have port req_data, input, REQ_COUNT x 32 bits: per-port packet data.
REQ-008 The block SHALL have port ack, output, REQ_COUNT bits: one-cycle pulse, packet of that port pushed.
REQ-009 The block SHALL have port tx_full, input, 1 bit: Hedios serial tx queue full.
REQ-010 The block SHALL have port tx_command, output, 8 bits: command to the tx queue.
REQ-011 The block SHALL have port tx_data, output, 32 bits: data to the tx queue.
REQ-012 The block SHALL have port tx_push_packet, output, 1 bit: one-cycle push strobe.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE or a lock is held.

Function
REQ-014 The block SHALL register all outputs; no output is combinationally derived from any input.
REQ-015 The FSM SHALL have three states: IDLE, PUSH and GAP.
REQ-016 IDLE: the block SHALL evaluate arbitration only when tx_full=0 and req is non-zero, latch the winner index, its command and its data, and go to PUSH; otherwise it SHALL stay in IDLE.
REQ-017 PUSH: the block SHALL drive tx_push_packet=1 and ack[winner]=1 for exactly one cycle, with tx_command/tx_data holding the latched values, and go to GAP.
REQ-018 GAP: the block SHALL wait one cycle so that tx_full can reflect the push, then return to IDLE.
REQ-019 Latency SHALL be: request sampled in IDLE at cycle N, push and ack at N+1, next sample at N+3; minimum push spacing is 3 cycles.
REQ-020 The winner SHALL be selected in this order: (a) the lock owner, if a lock is held; (b) port 0, if req[0]=1; (c) round-robin over ports 1..REQ_COUNT-1, starting from rr_ptr.
REQ-021 After an ack on port k>=1, rr_ptr SHALL become k+1, wrapping to 1 after REQ_COUNT-1; an ack on port 0 SHALL leave rr_ptr unchanged.
REQ-022 If req_lock[winner]=1 at PUSH, a lock SHALL be set to the winner.
REQ-023 In IDLE, the lock SHALL be cleared when the owner's req or req_lock is 0, and normal arbitration SHALL apply in that same cycle.
REQ-024 While a lock is held, port 0 SHALL NOT preempt the lock owner.
REQ-025 A requester SHALL hold req, command and data stable until its ack; a req dropped before it is sampled SHALL produce no push.
REQ-026 A req still high in the cycle after ack SHALL be treated as a new packet.
REQ-027 tx_full=1 in IDLE SHALL stall arbitration indefinitely with no push and no ack; tx_full in PUSH or GAP SHALL be ignored because it was sampled before the push.
REQ-028 tx_command/tx_data SHALL hold their last pushed value outside PUSH.
REQ-029 rr_ptr arithmetic SHALL be modulo over ports 1..REQ_COUNT-1 with width clog2(REQ_COUNT); with REQ_COUNT=2, port 1 SHALL always be the RR winner.

Reset
REQ-030 rst_n low SHALL immediately set state=IDLE, rr_ptr=1, lock cleared, ack=0, tx_push_packet=0, tx_command=0, tx_data=0 and busy=0.
REQ-031 An assertion of rst_n during PUSH SHALL suppress the push in progress, and no ack for it SHALL follow after release.
REQ-032 After rst_n deasserts, the first arbitration SHALL occur no earlier than the first rising edge.

Structure
REQ-033 The shared package hedios_pkg SHALL hold the HDC_* endpoint command codes, packet widths (command 8, data 32) and the FSM state encoding.
REQ-034 The round-robin selection SHALL be one combinational sub-module, hedios_rr_picker (inputs req mask, rr_ptr; outputs valid, index).
REQ-035 The FSM, lock and latches SHALL reside in hedios_tx_arbiter.

Verification
REQ-036 Scenario: REQ_COUNT=4, req=4'b0110 held, tx_full=0 -> acks alternate port1, port2, port1, with pushes 3 cycles apart.
REQ-037 Scenario: req=4'b1001 simultaneously -> port0 is pushed first (command 0x03), then port3; rr_ptr is then 1.
REQ-038 Scenario: port2 with req_lock=1 sends 5 packets while req[0]=1 -> 5 consecutive port2 pushes, then port0.
REQ-039 Scenario: tx_full=1 for 10 cycles with req=4'b0010 -> no push; push of 0x04/0xDEADBEEF occurs 1 cycle after tx_full falls.
REQ-040 Scenario: rst_n pulled low in the PUSH cycle -> tx_push_packet=0 at once; after release, rr_ptr=1 and the lock is clear.
REQ-041 Scenario: req[1] pulsed for 1 cycle while the FSM is in GAP -> no push and no ack.
